demux_16_64w_buf: RTL and testbench
===================================

# demux_16_64w_buf

Sequential 1-to-64 distributor for 16-bit DSP samples, the write-side counterpart of the team's 64-way word selectors. It accepts a valid/ready sample stream, writes consecutive samples into a 64-word register bank, and presents the completed frame on 64 parallel 16-bit outputs. A frame handshake releases the bank for the next fill. It sits between a serial sample source, such as an ADC or filter output, and the parallel-word consumers in the dsp tree.

## Interface
- Parameters: none. Word width 16 and depth 64 are fixed.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  16  sample word.
- in_valid  in  1  sample present.
- in_ready  out  1  block can accept a sample this cycle.
- in_sof  in  1  start of frame, qualified by in_valid && in_ready.
- o1..o64  out  16 each  frame words; o1 is the first sample of the frame.
- frame_valid  out  1  the bank holds a complete frame.
- frame_ack  in  1  consumer releases the frame, qualified by frame_valid.
- wr_idx  out  6  index of the next bank slot to be written.

## Operation
- Reset (async, rst_n=0):
  - o1..o64 = 0, wr_idx = 0, frame_valid = 0.
  - State = FILL, so in_ready = 1 as soon as rst_n deasserts.
- States:
  - FILL: in_ready=1, frame_valid=0.
  - FULL: in_ready=0, frame_valid=1.
- Accept event = in_valid && in_ready.
- On accept in FILL without in_sof:
  - write o(wr_idx+1) <= in_data; wr_idx <= wr_idx+1 (6-bit).
  - If wr_idx was 63: go to FULL and wrap wr_idx to 0.
- On accept with in_sof:
  - write o1 <= in_data; wr_idx <= 1.
  - The partial frame is abandoned. Its slots are not cleared; each is overwritten when refilled.
  - Stay in FILL.
- in_sof without accept: ignored.
- FULL:
  - o1..o64 are held stable; in_valid and in_sof are ignored.
  - On frame_ack: go to FILL next cycle.
- frame_ack in FILL: ignored.
- Only the addressed slot changes on a write; all other outputs hold.
- Reset mid-frame or mid-FULL:
  - Asynchronously clears the bank and all state to the reset values.
  - The pending frame is lost.

## Timing
- Sample accepted at edge N: the corresponding o-word shows the new value after edge N, with latency 1.
- 64th accept at edge N: frame_valid=1 and in_ready=0 from edge N through the frame_ack edge.
- frame_ack sampled at edge M: frame_valid=0 and in_ready=1 after M.
  - A sample presented in the cycle after M is accepted.
  - There is no accept in the ack cycle itself.
- Best-case throughput: 64 samples per 65 cycles, with ack asserted on the first FULL cycle.
- in_ready depends only on state. There is no combinational path from in_valid or frame_ack.
- All outputs are registered.

## Structure
- Shared package dsp_pkg holds:
  - constants SAMPLE_W=16 and FRAME_N=64;
  - the index width IDX_W=6;
  - a state enum {FILL, FULL}.
- Sub-module demux_ctrl holds the FSM and the wr_idx counter, and produces in_ready, frame_valid and a 64-bit one-hot write enable.
  - The top level instantiates demux_ctrl once.
  - The top level implements the 64 enabled 16-bit registers driving o1..o64.

## Test plan
- Reset release, then 64 samples 0x0001..0x0040 with continuous valid:
  - o1=0x0001, o64=0x0040.
  - frame_valid rises the cycle after the 64th accept.
  - in_ready=0 from that cycle.
- FULL hold: drive in_valid=1, in_data=0xFFFF for 10 cycles without ack:
  - all o-words unchanged;
  - wr_idx=0.
- Ack then refill: ack at edge M, then 0x1000+k:
  - frame_valid=0 after M;
  - the first sample is accepted the cycle after M and lands in o1=0x1000;
  - after 64 samples, o64=0x103F.
- in_sof mid-frame: 10 samples 0xA000.., then sof with 0xB000:
  - o1=0xB000, wr_idx=1;
  - o2..o10 keep 0xA001..0xA009 until overwritten;
  - the frame completes after 63 more samples.
- Gapped valid, random in_valid at 30% duty:
  - only accepted samples advance wr_idx;
  - frame contents match the accepted sequence.
- Async reset with wr_idx=37 and again in FULL:
  - all outputs 0 and frame_valid=0 immediately, without waiting for a clock edge;
  - in_ready=1 after deassert.

Source files
------------

// File: rtl/demux_16_64w_buf_pkg.sv
// Shared DSP package: sample/frame geometry, the fill/full state encoding
// and a one-hot helper used to address the register bank.
package dsp_pkg;

  localparam int SAMPLE_W = 16;
  localparam int FRAME_N  = 64;
  localparam int IDX_W    = 6;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_e;

  // One-hot decode of a bank slot index.
  function automatic logic [FRAME_N-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    logic [FRAME_N-1:0] oh;
    oh      = {FRAME_N{1'b0}};
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/demux_16_64w_buf_if.sv
// Sample-stream and frame-handshake bundle for demux_16_64w_buf.
//   in_data/in_valid/in_sof : sample source -> distributor
//   in_ready                : distributor -> sample source
//   frame_valid             : distributor -> frame consumer
//   frame_ack               : frame consumer -> distributor
// master = source/consumer side, slave = the distributor.
interface demux_16_64w_buf_if;
  import dsp_pkg::*;

  logic [SAMPLE_W-1:0] in_data;
  logic                in_valid;
  logic                in_ready;
  logic                in_sof;
  logic                frame_valid;
  logic                frame_ack;

  modport master (
    output in_data, in_valid, in_sof, frame_ack,
    input  in_ready, frame_valid
  );

  modport slave (
    input  in_data, in_valid, in_sof, frame_ack,
    output in_ready, frame_valid
  );

endinterface

// File: rtl/demux_16_64w_buf_ctrl.sv
// demux_ctrl: fill/full FSM and write-index counter for the 64-word bank.
//   clk, rst_n        : clock, async active-low reset
//   in_valid, in_sof  : sample qualifiers from the stream
//   frame_ack         : consumer releases a full frame
//   in_ready          : registered, high in FILL
//   frame_valid       : registered, high in FULL
//   wr_idx            : next slot to be written
//   wr_en             : one-hot bank write enable for the current cycle
module demux_ctrl
  import dsp_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic               in_sof,
  input  logic               frame_ack,
  output logic               in_ready,
  output logic               frame_valid,
  output logic [IDX_W-1:0]   wr_idx,
  output logic [FRAME_N-1:0] wr_en
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               ready_q, ready_d;
  logic               fvalid_q, fvalid_d;
  logic [IDX_W-1:0]   slot_s;
  logic               accept_s;

  // Next-state, index and write-enable decode.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wr_en    = {FRAME_N{1'b0}};
    slot_s   = idx_q;
    // ready_q mirrors (state_q == FILL), so accept never sees frame_ack.
    accept_s = in_valid && ready_q;
    case (state_q)
      FILL: begin
        if (accept_s) begin
          if (in_sof) begin
            // Restart: abandoned slots are left as-is until refilled.
            slot_s = {IDX_W{1'b0}};
            idx_d  = 6'd1;
          end else begin
            slot_s = idx_q;
            idx_d  = idx_q + 6'd1;  // wraps to 0 after slot 63
            if (idx_q == 6'd63) begin
              state_d = FULL;
            end else begin
              state_d = FILL;
            end
          end
          wr_en = idx_onehot(slot_s);
        end else begin
          state_d = FILL;
        end
      end
      FULL: begin
        if (frame_ack) begin
          state_d = FILL;
        end else begin
          state_d = FULL;
        end
      end
      default: begin
        state_d = FILL;
        idx_d   = {IDX_W{1'b0}};
      end
    endcase
    // Handshake outputs are registered copies of the next state.
    ready_d  = (state_d == FILL);
    fvalid_d = (state_d == FULL);
  end

  // State, index and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FILL;
      idx_q    <= {IDX_W{1'b0}};
      ready_q  <= 1'b1;
      fvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      ready_q  <= ready_d;
      fvalid_q <= fvalid_d;
    end
  end

  assign in_ready    = ready_q;
  assign frame_valid = fvalid_q;
  assign wr_idx      = idx_q;

endmodule

// File: rtl/demux_16_64w_buf.sv
// demux_16_64w_buf: sequential 1-to-64 distributor for 16-bit samples.
// Consecutive accepted samples fill a 64-word register bank; the completed
// frame is presented on o1..o64 (o1 = first sample) until frame_ack.
//   clk, rst_n : clock, async active-low reset
//   bus        : sample stream + frame handshake (slave side)
//   o1..o64    : registered frame words
//   wr_idx     : index of the next slot to be written
module demux_16_64w_buf
  import dsp_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  demux_16_64w_buf_if.slave    bus,
  output logic [SAMPLE_W-1:0]  o1,  o2,  o3,  o4,  o5,  o6,  o7,  o8,
  output logic [SAMPLE_W-1:0]  o9,  o10, o11, o12, o13, o14, o15, o16,
  output logic [SAMPLE_W-1:0]  o17, o18, o19, o20, o21, o22, o23, o24,
  output logic [SAMPLE_W-1:0]  o25, o26, o27, o28, o29, o30, o31, o32,
  output logic [SAMPLE_W-1:0]  o33, o34, o35, o36, o37, o38, o39, o40,
  output logic [SAMPLE_W-1:0]  o41, o42, o43, o44, o45, o46, o47, o48,
  output logic [SAMPLE_W-1:0]  o49, o50, o51, o52, o53, o54, o55, o56,
  output logic [SAMPLE_W-1:0]  o57, o58, o59, o60, o61, o62, o63, o64,
  output logic [IDX_W-1:0]     wr_idx
);

  logic [FRAME_N-1:0]  wr_en_s;
  logic [SAMPLE_W-1:0] bank_q [FRAME_N];
  logic [SAMPLE_W-1:0] bank_d [FRAME_N];

  demux_ctrl u_ctrl (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (bus.in_valid),
    .in_sof      (bus.in_sof),
    .frame_ack   (bus.frame_ack),
    .in_ready    (bus.in_ready),
    .frame_valid (bus.frame_valid),
    .wr_idx      (wr_idx),
    .wr_en       (wr_en_s)
  );

  // Only the enabled slot loads the sample; every other slot holds.
  always_comb begin
    for (int i = 0; i < FRAME_N; i++) begin
      if (wr_en_s[i]) begin
        bank_d[i] = bus.in_data;
      end else begin
        bank_d[i] = bank_q[i];
      end
    end
  end

  // Frame register bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FRAME_N; i++) begin
        bank_q[i] <= {SAMPLE_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < FRAME_N; i++) begin
        bank_q[i] <= bank_d[i];
      end
    end
  end

  assign o1  = bank_q[0];  assign o2  = bank_q[1];  assign o3  = bank_q[2];  assign o4  = bank_q[3];
  assign o5  = bank_q[4];  assign o6  = bank_q[5];  assign o7  = bank_q[6];  assign o8  = bank_q[7];
  assign o9  = bank_q[8];  assign o10 = bank_q[9];  assign o11 = bank_q[10]; assign o12 = bank_q[11];
  assign o13 = bank_q[12]; assign o14 = bank_q[13]; assign o15 = bank_q[14]; assign o16 = bank_q[15];
  assign o17 = bank_q[16]; assign o18 = bank_q[17]; assign o19 = bank_q[18]; assign o20 = bank_q[19];
  assign o21 = bank_q[20]; assign o22 = bank_q[21]; assign o23 = bank_q[22]; assign o24 = bank_q[23];
  assign o25 = bank_q[24]; assign o26 = bank_q[25]; assign o27 = bank_q[26]; assign o28 = bank_q[27];
  assign o29 = bank_q[28]; assign o30 = bank_q[29]; assign o31 = bank_q[30]; assign o32 = bank_q[31];
  assign o33 = bank_q[32]; assign o34 = bank_q[33]; assign o35 = bank_q[34]; assign o36 = bank_q[35];
  assign o37 = bank_q[36]; assign o38 = bank_q[37]; assign o39 = bank_q[38]; assign o40 = bank_q[39];
  assign o41 = bank_q[40]; assign o42 = bank_q[41]; assign o43 = bank_q[42]; assign o44 = bank_q[43];
  assign o45 = bank_q[44]; assign o46 = bank_q[45]; assign o47 = bank_q[46]; assign o48 = bank_q[47];
  assign o49 = bank_q[48]; assign o50 = bank_q[49]; assign o51 = bank_q[50]; assign o52 = bank_q[51];
  assign o53 = bank_q[52]; assign o54 = bank_q[53]; assign o55 = bank_q[54]; assign o56 = bank_q[55];
  assign o57 = bank_q[56]; assign o58 = bank_q[57]; assign o59 = bank_q[58]; assign o60 = bank_q[59];
  assign o61 = bank_q[60]; assign o62 = bank_q[61]; assign o63 = bank_q[62]; assign o64 = bank_q[63];

endmodule

// File: tb/tb_demux_16_64w_buf.sv
// Self-checking bench for demux_16_64w_buf: a behavioural frame model plus a
// scoreboard queue of (slot, data) expectations popped after each edge.
module tb_demux_16_64w_buf;
  import dsp_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  demux_16_64w_buf_if bus ();
  logic [15:0] o_w [64];
  logic [5:0]  wr_idx;

  demux_16_64w_buf dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .o1(o_w[0]),   .o2(o_w[1]),   .o3(o_w[2]),   .o4(o_w[3]),   .o5(o_w[4]),   .o6(o_w[5]),   .o7(o_w[6]),   .o8(o_w[7]),
    .o9(o_w[8]),   .o10(o_w[9]),  .o11(o_w[10]), .o12(o_w[11]), .o13(o_w[12]), .o14(o_w[13]), .o15(o_w[14]), .o16(o_w[15]),
    .o17(o_w[16]), .o18(o_w[17]), .o19(o_w[18]), .o20(o_w[19]), .o21(o_w[20]), .o22(o_w[21]), .o23(o_w[22]), .o24(o_w[23]),
    .o25(o_w[24]), .o26(o_w[25]), .o27(o_w[26]), .o28(o_w[27]), .o29(o_w[28]), .o30(o_w[29]), .o31(o_w[30]), .o32(o_w[31]),
    .o33(o_w[32]), .o34(o_w[33]), .o35(o_w[34]), .o36(o_w[35]), .o37(o_w[36]), .o38(o_w[37]), .o39(o_w[38]), .o40(o_w[39]),
    .o41(o_w[40]), .o42(o_w[41]), .o43(o_w[42]), .o44(o_w[43]), .o45(o_w[44]), .o46(o_w[45]), .o47(o_w[46]), .o48(o_w[47]),
    .o49(o_w[48]), .o50(o_w[49]), .o51(o_w[50]), .o52(o_w[51]), .o53(o_w[52]), .o54(o_w[53]), .o55(o_w[54]), .o56(o_w[55]),
    .o57(o_w[56]), .o58(o_w[57]), .o59(o_w[58]), .o60(o_w[59]), .o61(o_w[60]), .o62(o_w[61]), .o63(o_w[62]), .o64(o_w[63]),
    .wr_idx(wr_idx)
  );

  int err_cnt = 0;
  int chk_cnt = 0;

  // Behavioural frame model.
  logic [15:0] m_bank [64];
  logic [5:0]  m_idx;
  logic        m_full;

  typedef struct {
    int          slot;
    logic [15:0] data;
  } exp_t;
  exp_t sb_q [$];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) m_bank[i] = 16'h0000;
    m_idx  = 6'd0;
    m_full = 1'b0;
    sb_q.delete();
  endtask

  // One clock of stimulus; called just after a rising edge.
  task automatic cycle(input bit v, input logic [15:0] d, input bit sof, input bit ack);
    exp_t e;
    bit   acc;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_sof    = sof;
    bus.frame_ack = ack;
    #1;
    check_val("in_ready_pre", {31'd0, bus.in_ready}, {31'd0, !m_full});
    acc = v && !m_full;
    if (acc) begin
      e.slot = sof ? 0 : int'(m_idx);
      e.data = d;
      sb_q.push_back(e);
      m_bank[e.slot] = d;
      if (!sof && m_idx == 6'd63) m_full = 1'b1;
      m_idx = sof ? 6'd1 : m_idx + 6'd1;
    end else if (m_full && ack) begin
      m_full = 1'b0;
    end
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val($sformatf("o%0d", e.slot + 1), {16'd0, o_w[e.slot]}, {16'd0, e.data});
    end
    check_val("wr_idx", {26'd0, wr_idx}, {26'd0, m_idx});
    check_val("frame_valid", {31'd0, bus.frame_valid}, {31'd0, m_full});
    check_val("in_ready", {31'd0, bus.in_ready}, {31'd0, !m_full});
    bus.in_valid  = 1'b0;
    bus.in_sof    = 1'b0;
    bus.frame_ack = 1'b0;
  endtask

  task automatic check_bank(input string tag);
    for (int i = 0; i < 64; i++)
      check_val($sformatf("%s_o%0d", tag, i + 1), {16'd0, o_w[i]}, {16'd0, m_bank[i]});
  endtask

  // Assert reset mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 64; i++)
      check_val($sformatf("%s_rst_o%0d", tag, i + 1), {16'd0, o_w[i]}, 32'd0);
    check_val({tag, "_rst_fv"}, {31'd0, bus.frame_valid}, 32'd0);
    check_val({tag, "_rst_idx"}, {26'd0, wr_idx}, 32'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    check_val({tag, "_rdy_after"}, {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int budget;
    bus.in_valid  = 1'b0;
    bus.in_data   = 16'h0000;
    bus.in_sof    = 1'b0;
    bus.frame_ack = 1'b0;
    model_clear();
    #2;
    check_val("rst_fv", {31'd0, bus.frame_valid}, 32'd0);
    check_val("rst_idx", {26'd0, wr_idx}, 32'd0);
    check_val("rst_o1", {16'd0, o_w[0]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("rst_rdy", {31'd0, bus.in_ready}, 32'd1);

    // Straight fill 1..64.
    for (int k = 0; k < 64; k++) cycle(1'b1, 16'(k + 1), 1'b0, 1'b0);
    check_val("t1_o1", {16'd0, o_w[0]}, 32'h0001);
    check_val("t1_o64", {16'd0, o_w[63]}, 32'h0040);
    check_val("t1_fv", {31'd0, bus.frame_valid}, 32'd1);

    // FULL holds against valid and sof.
    for (int k = 0; k < 10; k++) cycle(1'b1, 16'hFFFF, k[0], 1'b0);
    check_bank("hold");
    check_val("hold_idx", {26'd0, wr_idx}, 32'd0);

    // Ack then refill 0x1000+k.
    cycle(1'b0, 16'h0000, 1'b0, 1'b1);
    check_val("ack_fv", {31'd0, bus.frame_valid}, 32'd0);
    for (int k = 0; k < 64; k++) begin
      cycle(1'b1, 16'h1000 + 16'(k), 1'b0, 1'b0);
      if (k == 0) check_val("refill_o1", {16'd0, o_w[0]}, 32'h1000);
    end
    check_val("refill_o64", {16'd0, o_w[63]}, 32'h103F);
    check_bank("refill");
    cycle(1'b0, 16'h0000, 1'b0, 1'b1);

    // sof mid-frame.
    for (int k = 0; k < 10; k++) cycle(1'b1, 16'hA000 + 16'(k), 1'b0, 1'b0);
    cycle(1'b1, 16'hB000, 1'b1, 1'b0);
    check_val("sof_o1", {16'd0, o_w[0]}, 32'hB000);
    check_val("sof_idx", {26'd0, wr_idx}, 32'd1);
    check_val("sof_o2", {16'd0, o_w[1]}, 32'hA001);
    check_val("sof_o10", {16'd0, o_w[9]}, 32'hA009);
    for (int k = 0; k < 63; k++) cycle(1'b1, 16'hC000 + 16'(k), 1'b0, 1'b0);
    check_val("sof_fv", {31'd0, bus.frame_valid}, 32'd1);
    check_bank("sof");
    cycle(1'b0, 16'h0000, 1'b0, 1'b1);

    // Gapped valid at ~30% duty.
    budget = 0;
    while (!m_full && budget < 3000) begin
      cycle($urandom_range(99) < 30, 16'($urandom), 1'b0, 1'b0);
      budget++;
    end
    check_val("gap_done", {31'd0, bus.frame_valid}, 32'd1);
    check_bank("gap");
    cycle(1'b0, 16'h0000, 1'b0, 1'b1);

    // Async reset mid-frame (wr_idx=37) and in FULL.
    for (int k = 0; k < 37; k++) cycle(1'b1, 16'h5000 + 16'(k), 1'b0, 1'b0);
    check_val("pre_rst_idx", {26'd0, wr_idx}, 32'd37);
    do_reset("mid");
    for (int k = 0; k < 64; k++) cycle(1'b1, 16'h6000 + 16'(k), 1'b0, 1'b0);
    check_val("pre_rst_fv", {31'd0, bus.frame_valid}, 32'd1);
    do_reset("full");
    cycle(1'b1, 16'h7777, 1'b0, 1'b0);
    check_val("post_rst_o1", {16'd0, o_w[0]}, 32'h7777);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
